msrv32_imm_adder: RTL and testbench

Immediate adder for the MSRV32 (RV32I) core. It forms the target/effective address for branches, JAL, JALR, AUIPC and load/store. The address is the sum of a sign-extended immediate and either the program counter or register operand rs1. It sits in the decode/execute stage and feeds the PC mux and the load/store unit.

---
 rtl/msrv32_imm_adder.sv | 45 ++++
 tb/tb_msrv32_imm_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/msrv32_imm_adder.sv
// Immediate adder: base (pc or rs1) plus sign-extended immediate, with alignment flags.
// Define MSRV32_IADDER_REG_EN to register the outputs; the default build is combinational.
module msrv32_imm_adder (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs_1_in,
  input  logic        iadder_src_in,
  input  logic [31:0] imm_in,
  output logic [31:0] iadder_out,
  output logic        iadder_misaligned_h_out,
  output logic        iadder_misaligned_w_out
);

  logic [31:0] base;
  logic [31:0] sum;

  // Carry-out is dropped; a negative immediate arrives as two's complement.
  assign base = iadder_src_in ? rs_1_in : pc_in;
  assign sum  = base + imm_in;

`ifdef MSRV32_IADDER_REG_EN
  // Flags are registered alongside the sum so all three outputs stay coherent.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      iadder_out              <= 32'h0000_0000;
      iadder_misaligned_h_out <= 1'b0;
      iadder_misaligned_w_out <= 1'b0;
    end else begin
      iadder_out              <= sum;
      iadder_misaligned_h_out <= sum[0];
      iadder_misaligned_w_out <= |sum[1:0];
    end
  end
`else
  // Clock and reset are present only for port compatibility with the registered build.
  logic unused_ctrl;
  assign unused_ctrl = ms_riscv32_mp_clk_in ^ ms_riscv32_mp_rst_in;

  assign iadder_out              = sum;
  assign iadder_misaligned_h_out = iadder_out[0];
  assign iadder_misaligned_w_out = |iadder_out[1:0];
`endif

endmodule

// File: tb/tb_msrv32_imm_adder.sv
// Directed bench for msrv32_imm_adder; covers both the combinational and the
// MSRV32_IADDER_REG_EN registered build.
module tb_msrv32_imm_adder;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic        src;
  logic [31:0] imm;
  logic [31:0] iadder_out;
  logic        mis_h;
  logic        mis_w;

  int checks = 0;
  int errors = 0;

  // Expected entries: {w, h, out}
  logic [33:0] exp_q[$];

  msrv32_imm_adder dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_in   (rst),
    .pc_in                  (pc),
    .rs_1_in                (rs1),
    .iadder_src_in          (src),
    .imm_in                 (imm),
    .iadder_out             (iadder_out),
    .iadder_misaligned_h_out(mis_h),
    .iadder_misaligned_w_out(mis_w)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver
  task automatic drive(input logic [31:0] p, input logic [31:0] r, input logic s,
                       input logic [31:0] i, input logic [31:0] e_out,
                       input logic e_h, input logic e_w);
    pc  = p;
    rs1 = r;
    src = s;
    imm = i;
    exp_q.push_back({e_w, e_h, e_out});
  endtask

  // Scoreboard
  task automatic check_out(input string tag);
    logic [33:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s queue: got empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (iadder_out === e[31:0]) else begin
        errors++;
        $error("FAIL %s out: got %h expected %h", tag, iadder_out, e[31:0]);
      end
      checks++;
      assert (mis_h === e[32]) else begin
        errors++;
        $error("FAIL %s h: got %b expected %b", tag, mis_h, e[32]);
      end
      checks++;
      assert (mis_w === e[33]) else begin
        errors++;
        $error("FAIL %s w: got %b expected %b", tag, mis_w, e[33]);
      end
    end
  endtask

  // Apply one vector and sample after it settles (comb) or after the next edge (reg).
  task automatic run_case(input string tag, input logic [31:0] p, input logic [31:0] r,
                          input logic s, input logic [31:0] i, input logic [31:0] e_out,
                          input logic e_h, input logic e_w);
    @(negedge clk);
    drive(p, r, s, i, e_out, e_h, e_w);
`ifdef MSRV32_IADDER_REG_EN
    @(posedge clk);
`endif
    #1;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1;
    pc  = '0;
    rs1 = '0;
    src = 1'b0;
    imm = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef MSRV32_IADDER_REG_EN
    exp_q.push_back(34'h0);
    check_out("reset_state");
    // Inputs change but the output must hold until the next edge.
    @(negedge clk);
    rst = 1'b0;
    drive(32'h12233435, 32'hAAAAAA00, 1'b1, 32'h0000000D, 32'hAAAAAA0D, 1'b1, 1'b1);
    #1;
    checks++;
    assert (iadder_out === 32'h0) else begin
      errors++;
      $error("FAIL latency_pre_edge: got %h expected %h", iadder_out, 32'h0);
    end
    @(posedge clk);
    #1;
    check_out("case1_reg");
`else
    // Reset held high: combinational output is unaffected.
    exp_q.push_back(34'h0);
    check_out("reset_state");
    drive(32'h12233435, 32'hAAAAAA00, 1'b1, 32'h0000000D, 32'hAAAAAA0D, 1'b1, 1'b1);
    #1;
    check_out("case1_in_reset");
    @(negedge clk);
    rst = 1'b0;
`endif

    run_case("case1",      32'h12233435, 32'hAAAAAA00, 1'b1, 32'h0000000D, 32'hAAAAAA0D, 1'b1, 1'b1);
    run_case("case2",      32'h12233435, 32'hAAAAAA00, 1'b0, 32'h12345678, 32'h24578AAD, 1'b1, 1'b1);
    run_case("case3_pc",   32'hABCD1234, 32'hFADBC123, 1'b0, 32'h0100A00D, 32'hACCDB241, 1'b1, 1'b1);
    run_case("case3_rs1",  32'hABCD1234, 32'hFADBC123, 1'b1, 32'h0100A00D, 32'hFBDC6130, 1'b0, 1'b0);
    run_case("wrap",       32'h00000000, 32'hFFFFFFFC, 1'b1, 32'h00000008, 32'h00000004, 1'b0, 1'b0);
    run_case("neg_imm",    32'h00000010, 32'h00000000, 1'b0, 32'hFFFFFFFC, 32'h0000000C, 1'b0, 1'b0);
    run_case("small_pc0",  32'h00000010, 32'h00000000, 1'b0, 32'h00000004, 32'h00000014, 1'b0, 1'b0);
    run_case("small_rs0",  32'h00000010, 32'h00000020, 1'b1, 32'h00000008, 32'h00000028, 1'b0, 1'b0);
    run_case("small_pc1",  32'h00000030, 32'h00000020, 1'b0, 32'h00000010, 32'h00000040, 1'b0, 1'b0);
    run_case("small_rs1",  32'h00000030, 32'h00000040, 1'b1, 32'h00000020, 32'h00000060, 1'b0, 1'b0);
    run_case("half_align", 32'h00000100, 32'h00000000, 1'b0, 32'h00000002, 32'h00000102, 1'b0, 1'b1);
    run_case("odd_rs1",    32'h00000000, 32'h00000003, 1'b1, 32'h00000000, 32'h00000003, 1'b1, 1'b1);

`ifdef MSRV32_IADDER_REG_EN
    // Reset wins over new inputs on the same edge.
    @(negedge clk);
    rst = 1'b1;
    pc  = 32'h12233435;
    rs1 = 32'hAAAAAA00;
    src = 1'b0;
    imm = 32'h12345678;
    exp_q.push_back(34'h0);
    @(posedge clk);
    #1;
    check_out("midstream_reset");
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
